// File: rtl/mem_access_ctrl_pkg.sv
// Shared bus definitions for the CPU <-> MEMORY access controller:
// default widths, wait-counter width, EN encoding and FSM state encoding.
package mem_access_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned WAIT_CNT_W = 4;

  localparam logic MEM_EN_WRITE = 1'b1;
  localparam logic MEM_EN_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MAR/EN/CS for single CPU read/write accesses with programmable
// wait states, returns read data with a done pulse, and counts accesses.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_en,
  output logic              mem_cs,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  state_e                  state_q;
  state_e                  state_d;
  logic [WAIT_CNT_W-1:0]   wait_q;
  logic                    we_q;
  logic                    we_d;
  logic                    accept_c;
  logic                    last_access_c;
  logic                    ready_d;
  logic                    done_d;
  logic                    rvalid_d;
  logic                    cs_d;
  logic                    en_d;
  logic                    rd_inc_c;
  logic                    wr_inc_c;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus next-cycle output decode (outputs follow the state entered)
  always_comb begin
    state_d       = state_q;
    accept_c      = 1'b0;
    we_d          = we_q;
    last_access_c = (wait_q == '0);
    ready_d       = 1'b0;
    done_d        = 1'b0;
    rvalid_d      = 1'b0;
    cs_d          = 1'b0;
    en_d          = MEM_EN_READ;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          accept_c = 1'b1;
          we_d     = cpu_we;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (last_access_c) state_d = ST_HOLD;
      ST_HOLD:   state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_IDLE:  ready_d = 1'b1;
      ST_SETUP, ST_HOLD: en_d = we_d ? MEM_EN_WRITE : MEM_EN_READ;
      ST_ACCESS: begin
        cs_d = 1'b1;
        en_d = we_d ? MEM_EN_WRITE : MEM_EN_READ;
      end
      ST_RESP: begin
        done_d   = 1'b1;
        rvalid_d = ~we_d;
      end
      default: ready_d = 1'b0;
    endcase
  end

  // Request latches and wait-state down-counter; MAR keeps its value when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_q    <= '0;
    end else begin
      if (accept_c) begin
        we_q      <= cpu_we;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end
      if (state_q == ST_SETUP) begin
        wait_q <= WAIT_CNT_W'(WAIT_CYCLES);
      end else if ((state_q == ST_ACCESS) && !last_access_c) begin
        wait_q <= wait_q - WAIT_CNT_W'(1);
      end
    end
  end

  // Registered control outputs and read-data capture on the last ACCESS edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_ready  <= 1'b1;
      cpu_done   <= 1'b0;
      cpu_rvalid <= 1'b0;
      mem_cs     <= 1'b0;
      mem_en     <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_ready  <= ready_d;
      cpu_done   <= done_d;
      cpu_rvalid <= rvalid_d;
      mem_cs     <= cs_d;
      mem_en     <= en_d;
      if ((state_q == ST_ACCESS) && last_access_c && !we_q) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

  // Count on entry to RESP so the new count is visible alongside cpu_done
  assign rd_inc_c = (state_q == ST_HOLD) && !we_q;
  assign wr_inc_c = (state_q == ST_HOLD) &&  we_q;

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (rd_inc_c),
    .count (rd_count)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (wr_inc_c),
    .count (wr_count)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: three builds (WAIT_CYCLES 0, 1, 15)
// driven with table vectors plus held-request and reset-abort sequences.
module tb_mem_access_ctrl;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req    [3];
  logic        ready  [3];
  logic        done   [3];
  logic        rvalid [3];
  logic        cs     [3];
  logic        en     [3];
  logic [23:0] rdata  [3];
  logic [7:0]  maddr  [3];
  logic [23:0] mwdata [3];
  logic [23:0] mrdata [3];
  logic        we;
  logic [7:0]  addr;
  logic [23:0] wdata;
  logic [1:0]  rd0, wr0;
  logic [15:0] rd1, wr1, rd15, wr15;
  logic [23:0] mem1 [256];

  int checks = 0;
  int errors = 0;
  int rd_exp [3];
  int wr_exp [3];
  int cmax   [3] = '{3, 65535, 65535};
  int waitc  [3] = '{0, 1, 15};

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [23:0] wdata;
    logic [23:0] exp_rdata;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [23:0] pat(input logic [7:0] a);
    return {16'hA55A, a};
  endfunction

  // Builds 0 and 2 see a fixed address pattern; build 1 has a real memory
  assign mrdata[0] = pat(maddr[0]);
  assign mrdata[2] = pat(maddr[2]);
  assign mrdata[1] = mem1[maddr[1]];
  always @(posedge clock) if (cs[1] && en[1]) mem1[maddr[1]] <= mwdata[1];

  mem_access_ctrl #(.WAIT_CYCLES(0), .CNT_W(2)) u_w0 (
    .clock(clock), .reset(reset), .cpu_req(req[0]), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ready(ready[0]), .cpu_done(done[0]), .cpu_rvalid(rvalid[0]),
    .cpu_rdata(rdata[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]),
    .mem_en(en[0]), .mem_cs(cs[0]), .rd_count(rd0), .wr_count(wr0));

  mem_access_ctrl #(.WAIT_CYCLES(1), .CNT_W(16)) u_w1 (
    .clock(clock), .reset(reset), .cpu_req(req[1]), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ready(ready[1]), .cpu_done(done[1]), .cpu_rvalid(rvalid[1]),
    .cpu_rdata(rdata[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]),
    .mem_en(en[1]), .mem_cs(cs[1]), .rd_count(rd1), .wr_count(wr1));

  mem_access_ctrl #(.WAIT_CYCLES(15), .CNT_W(16)) u_w15 (
    .clock(clock), .reset(reset), .cpu_req(req[2]), .cpu_we(we), .cpu_addr(addr),
    .cpu_wdata(wdata), .cpu_ready(ready[2]), .cpu_done(done[2]), .cpu_rvalid(rvalid[2]),
    .cpu_rdata(rdata[2]), .mem_addr(maddr[2]), .mem_wdata(mwdata[2]), .mem_rdata(mrdata[2]),
    .mem_en(en[2]), .mem_cs(cs[2]), .rd_count(rd15), .wr_count(wr15));

  function automatic int unsigned rd_of(input int k);
    case (k)
      0:       return {30'd0, rd0};
      1:       return {16'd0, rd1};
      default: return {16'd0, rd15};
    endcase
  endfunction

  function automatic int unsigned wr_of(input int k);
    case (k)
      0:       return {30'd0, wr0};
      1:       return {16'd0, wr1};
      default: return {16'd0, wr15};
    endcase
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One access on build k, called at a negedge while that build is idle
  task automatic do_access(input int k, input logic w, input logic [7:0] a,
                           input logic [23:0] d, input logic [23:0] exp_rd);
    int done_at  = -1;
    int cs_n     = 0;
    int en_n     = 0;
    int busy_rdy = 0;
    int bus_bad  = 0;
    int rv_done  = 0;
    we = w; addr = a; wdata = d; req[k] = 1'b1;
    for (int n = 1; n <= 40 && done_at < 0; n++) begin
      @(posedge clock); @(negedge clock);
      if (n == 1) req[k] = 1'b0;
      if (cs[k]) cs_n++;
      if (en[k]) en_n++;
      if (ready[k]) busy_rdy++;
      if ((cs[k] || en[k]) && (maddr[k] !== a || (w && mwdata[k] !== d))) bus_bad++;
      if (done[k]) begin
        done_at = n;
        rv_done = int'(rvalid[k]);
      end
    end
    if (w) wr_exp[k] = (wr_exp[k] == cmax[k]) ? cmax[k] : wr_exp[k] + 1;
    else   rd_exp[k] = (rd_exp[k] == cmax[k]) ? cmax[k] : rd_exp[k] + 1;
    chk($sformatf("done_cycle k%0d a%0h", k, a), done_at, 4 + waitc[k]);
    chk($sformatf("cs_width k%0d a%0h", k, a), cs_n, waitc[k] + 1);
    chk($sformatf("en_width k%0d a%0h", k, a), en_n, w ? waitc[k] + 3 : 0);
    chk($sformatf("ready_while_busy k%0d", k), busy_rdy, 0);
    chk($sformatf("bus_addr_data k%0d a%0h", k, a), bus_bad, 0);
    chk($sformatf("rvalid_at_done k%0d", k), rv_done, w ? 0 : 1);
    @(posedge clock); @(negedge clock);
    chk($sformatf("done_single_pulse k%0d", k), int'(done[k]), 0);
    chk($sformatf("ready_after k%0d", k), int'(ready[k]), 1);
    chk($sformatf("rdata k%0d a%0h", k, a), rdata[k], exp_rd);
    chk($sformatf("rd_count k%0d", k), rd_of(k), rd_exp[k]);
    chk($sformatf("wr_count k%0d", k), wr_of(k), wr_exp[k]);
  endtask

  initial begin : main
    int dn, cs_rise, rdy_n, bad_done, stray;
    logic prev_cs;

    tbl[0] = '{1'b1, 8'h04, 24'h000060, 24'h000000};
    tbl[1] = '{1'b0, 8'h04, 24'h000000, 24'h000060};
    tbl[2] = '{1'b1, 8'hFF, 24'hABCDEF, 24'h000060};
    tbl[3] = '{1'b0, 8'hFF, 24'h000000, 24'hABCDEF};
    tbl[4] = '{1'b1, 8'h00, 24'hFFFFFF, 24'hABCDEF};
    tbl[5] = '{1'b0, 8'h04, 24'h000000, 24'h000060};
    tbl[6] = '{1'b0, 8'h00, 24'h000000, 24'hFFFFFF};

    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; rd_exp[k] = 0; wr_exp[k] = 0;
    end
    repeat (2) @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_ready k%0d", k), int'(ready[k]), 1);
      chk($sformatf("reset_cs_en k%0d", k), {cs[k], en[k], done[k], rvalid[k]}, 0);
      chk($sformatf("reset_counts k%0d", k), rd_of(k) + wr_of(k), 0);
    end
    reset = 1'b0;
    @(negedge clock);

    // WAIT_CYCLES=0 build with a 2-bit counter: fourth read must saturate at 3
    for (int i = 0; i < 4; i++) do_access(0, 1'b0, 8'h10 + 8'(i), 24'h0, pat(8'h10 + 8'(i)));

    // WAIT_CYCLES=15 build: 16-cycle CS; the write leaves read data alone
    do_access(2, 1'b0, 8'h33, 24'h0, pat(8'h33));
    do_access(2, 1'b1, 8'h44, 24'h123456, pat(8'h33));

    for (int i = 0; i < 7; i++)
      do_access(1, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);

    // Held request: three reads accepted 6 cycles apart, no fourth access
    dn = 0; cs_rise = 0; rdy_n = 0; bad_done = 0; prev_cs = 1'b0;
    we = 1'b0; addr = 8'h04; req[1] = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clock); @(negedge clock);
      if (n == 13) req[1] = 1'b0;
      if (done[1]) begin
        dn++;
        if (n != 5 && n != 11 && n != 17) bad_done++;
      end
      if (cs[1] && !prev_cs) cs_rise++;
      prev_cs = cs[1];
      if (ready[1]) rdy_n++;
    end
    rd_exp[1] += 3;
    chk("held_done_pulses", dn, 3);
    chk("held_done_timing", bad_done, 0);
    chk("held_cs_bursts", cs_rise, 3);
    chk("held_ready_cycles", rdy_n, 9);
    chk("held_rd_count", rd_of(1), rd_exp[1]);
    chk("held_rdata", rdata[1], 24'h000060);

    // Reset during ACCESS of a read: outputs drop at once, access is dropped
    we = 1'b0; addr = 8'hFF; req[1] = 1'b1;
    @(posedge clock); @(negedge clock);
    req[1] = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("abort_cs_before_reset", int'(cs[1]), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_async_cs_en", {cs[1], en[1]}, 0);
    chk("abort_async_ready", int'(ready[1]), 1);
    chk("abort_async_counts", rd_of(1) + wr_of(1), 0);
    chk("abort_async_mar", maddr[1], 0);
    for (int k = 0; k < 3; k++) begin
      rd_exp[k] = 0; wr_exp[k] = 0;
    end
    @(negedge clock);
    reset = 1'b0;
    stray = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clock); @(negedge clock);
      if (done[1] || !ready[1] || cs[1]) stray++;
    end
    chk("abort_no_activity", stray, 0);
    chk("abort_rd_count", rd_of(1), 0);
    do_access(1, 1'b0, 8'hFF, 24'h0, 24'hABCDEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
